my_sub16_serial: RTL and testbench

//  Bit-serial unsigned subtractor: out = a - b, one bit per clock, with a borrow flag.

---
 rtl/my_sub16_serial.sv | 130 +++++++++++++
 tb/tb_my_sub16_serial.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/my_sub16_serial.sv
// Bit-serial unsigned subtractor (out = a - b, LSB first) with valid/ready on both sides.
// Optional SUB_SATURATE_EN: a borrowing result is clamped to zero instead of wrapping.
module my_sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             zero,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             a_bit, b_bit, diff_bit, bw_nxt;
  logic [WIDTH-1:0] res_nxt, res_fin;

  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] v, input logic bw);
`ifdef SUB_SATURATE_EN
    sat_result = bw ? '0 : v;
`else
    sat_result = v;
`endif
  endfunction

  // Index WIDTH-1 is the LSB: operands shift toward it, results enter at index 0
  // so the first (LSB) difference bit ends up at WIDTH-1 after WIDTH shifts.
  always_comb begin
    a_bit    = a_q[WIDTH-1];
    b_bit    = b_q[WIDTH-1];
    diff_bit = a_bit ^ b_bit ^ bw_q;
    bw_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    res_nxt  = {res_q[WIDTH-2:0], diff_bit};
    res_fin  = sat_result(res_nxt, bw_nxt);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          bw_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        res_d = res_nxt;
        bw_d  = bw_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d    = res_fin;
          borrow_d = bw_nxt;
          zero_d   = (res_fin == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign out         = out_q;
  assign borrow      = borrow_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_my_sub16_serial.sv
// Self-checking bench for my_sub16_serial: directed cases plus random operands
// against an arithmetic reference model (values bit-reversed onto the ports).
module tb_my_sub16_serial;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b, out;
  logic         borrow, zero, done_valid, done_ready;

  int errors = 0;
  int checks = 0;

  my_sub16_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b),
    .out(out), .borrow(borrow), .zero(zero),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Reference: plain modular arithmetic on numeric values.
  function automatic void model(input int unsigned av, input int unsigned bv,
                                output int unsigned eo, output int unsigned eb,
                                output int unsigned ez);
    int unsigned m;
    m  = (32'd1 << W) - 1;
    eo = (av + (m + 1) - bv) & m;
    eb = (av < bv) ? 1 : 0;
`ifdef SUB_SATURATE_EN
    if (eb == 1) eo = 0;
`endif
    ez = (eo == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int unsigned av, input int unsigned bv);
    int unsigned eo, eb, ez;
    model(av, bv, eo, eb, ez);
    chk({tag, "_out"}, 32'(rev(out)), eo);
    chk({tag, "_borrow"}, 32'(borrow), eb);
    chk({tag, "_zero"}, 32'(zero), ez);
  endtask

  task automatic run_op(input string tag, input int unsigned av, input int unsigned bv);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin tick(); n++; end
    chk({tag, "_ready"}, 32'(start_ready), 1);
    a = rev(W'(av));
    b = rev(W'(bv));
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    while (!done_valid && n < 40) begin tick(); n++; end
    chk({tag, "_latency"}, 32'(n), W);
    check_result(tag, av, bv);
  endtask

  task automatic consume(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk({tag, "_dv_drop"}, 32'(done_valid), 0);
    chk({tag, "_idle"}, 32'(start_ready), 1);
  endtask

  initial begin
    int unsigned ra, rb;
    int unsigned so, sb, sz;
    int seen;
    int unsigned pa[3];
    int unsigned pb[3];
    int acc_cyc[3];
    int k_acc, k_done, cyc;
    logic accept_now;

    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_out", 32'(out), 0);
    chk("rst_borrow", 32'(borrow), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_dv", 32'(done_valid), 0);
    chk("rst_ready", 32'(start_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("t1", 1000, 234);
    consume("t1");

    run_op("t2", 5, 7);
    consume("t2");

    run_op("t3", 43690, 43690);
    so = 32'(rev(out)); sb = 32'(borrow); sz = 32'(zero);
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_dv", 32'(done_valid), 1);
      chk("t3_hold_out", 32'(rev(out)), so);
      chk("t3_hold_borrow", 32'(borrow), sb);
      chk("t3_hold_zero", 32'(zero), sz);
      chk("t3_hold_ready", 32'(start_ready), 0);
    end
    start_valid = 1'b0;
    consume("t3");

    // Abort mid-shift: reset must discard the operation entirely.
    a = rev(16'd3); b = rev(16'd1); start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_dv", 32'(done_valid), 0);
    chk("t4_rst_out", 32'(out), 0);
    chk("t4_rst_ready", 32'(start_ready), 1);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (done_valid) seen++; end
    chk("t4_no_done", 32'(seen), 0);
    run_op("t4", 65535, 0);
    consume("t4");

    for (int i = 0; i < 10; i++) begin
      ra = $urandom & 32'hFFFF;
      rb = (i % 3 == 0) ? ra : ($urandom & 32'hFFFF);
      run_op($sformatf("rnd%0d", i), ra, rb);
      consume($sformatf("rnd%0d", i));
    end
    run_op("wrap", 0, 1);
    consume("wrap");

    // Back-to-back stream with done_ready tied high.
    pa[0] = 0; pb[0] = 0;
    pa[1] = 1; pb[1] = 0;
    pa[2] = 0; pb[2] = 65535;
    k_acc = 0; k_done = 0; cyc = 0;
    done_ready = 1'b1;
    a = rev(W'(pa[0])); b = rev(W'(pb[0])); start_valid = 1'b1;
    for (int t = 0; t < 200 && k_done < 3; t++) begin
      if (done_valid) begin
        check_result($sformatf("b2b%0d", k_done), pa[k_done], pb[k_done]);
        k_done++;
      end
      accept_now = start_ready && (k_acc < 3);
      tick();
      cyc++;
      if (accept_now) begin
        acc_cyc[k_acc] = cyc;
        k_acc++;
        if (k_acc < 3) begin
          a = rev(W'(pa[k_acc])); b = rev(W'(pb[k_acc]));
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    done_ready = 1'b0;
    chk("b2b_results", 32'(k_done), 3);
    chk("b2b_accepts", 32'(k_acc), 3);
    if (k_acc == 3) begin
      chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), W + 2);
      chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), W + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
